// File: rtl/pixel_fifo_if.sv
// Handshake bundle between the row serializer, the pixel FIFO and LCD scanout.
interface pixel_fifo_if #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 16
);
    logic                     flush_in;
    logic                     push_in;
    logic [WIDTH-1:0]         pixel_in;
    logic                     pop_in;
    logic [WIDTH-1:0]         pixel_out;
    logic                     valid_out;
    logic                     full_out;
    logic                     row_space_out;
    logic [$clog2(DEPTH):0]   count_out;
    logic                     overflow_out;
    logic                     underflow_out;

    modport master (
        output flush_in, push_in, pixel_in, pop_in,
        input  pixel_out, valid_out, full_out, row_space_out,
               count_out, overflow_out, underflow_out
    );

    modport slave (
        input  flush_in, push_in, pixel_in, pop_in,
        output pixel_out, valid_out, full_out, row_space_out,
               count_out, overflow_out, underflow_out
    );
endinterface

// File: rtl/pixel_fifo.sv
// Show-ahead pixel FIFO feeding LCD scanout; row_space_out gates the start of a tile-row fetch.
module pixel_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 16,
    parameter int ROW   = 8
) (
    input  logic          clk_in,
    input  logic          rst_in,
    pixel_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             pop_acc, push_acc;

    // A pop in the same cycle frees the slot a push needs when full.
    assign pop_acc  = bus.pop_in && (count_q != '0);
    assign push_acc = bus.push_in && ((count_q != CW'(DEPTH)) || pop_acc);

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.flush_in) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_acc)
                rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_acc)
                wr_ptr_d = wr_ptr_q + AW'(1);
            count_d = count_q + CW'(push_acc) - CW'(pop_acc);
            if (bus.push_in && !push_acc)
                overflow_d = 1'b1;
            if (bus.pop_in && !pop_acc)
                underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Array is not reset; stale entries are never visible because pixel_out is gated by count.
    always_ff @(posedge clk_in) begin
        if (!rst_in && !bus.flush_in && push_acc)
            mem_q[wr_ptr_q] <= bus.pixel_in;
    end

    assign bus.pixel_out     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.valid_out     = (count_q != '0);
    assign bus.full_out      = (count_q == CW'(DEPTH));
    assign bus.row_space_out = (count_q <= CW'(DEPTH - ROW));
    assign bus.count_out     = count_q;
    assign bus.overflow_out  = overflow_q;
    assign bus.underflow_out = underflow_q;
endmodule

// File: tb/tb_pixel_fifo.sv
// Scoreboard bench for pixel_fifo: a queue model tracks expected contents and sticky flags.
module tb_pixel_fifo;
    localparam int WIDTH = 6;
    localparam int DEPTH = 16;
    localparam int ROW   = 8;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    pixel_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pixel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ROW(ROW)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    logic [WIDTH-1:0] exp_q [$];
    bit               m_ovf;
    bit               m_udf;
    int               n_total = 0;
    int               n_pass  = 0;

    // One clock with the given inputs; the model is updated as the DUT should be.
    task automatic drive(input bit push, input logic [WIDTH-1:0] pix, input bit pop, input bit flush);
        bit pa, pu;
        bus.push_in  = push;
        bus.pixel_in = pix;
        bus.pop_in   = pop;
        bus.flush_in = flush;
        @(posedge clk_in);
        #1;
        bus.push_in  = 1'b0;
        bus.pop_in   = 1'b0;
        bus.flush_in = 1'b0;
        if (flush) begin
            exp_q.delete();
        end else begin
            pa = pop && (exp_q.size() != 0);
            pu = push && ((exp_q.size() != DEPTH) || pa);
            if (pop && !pa)  m_udf = 1'b1;
            if (push && !pu) m_ovf = 1'b1;
            if (pa) void'(exp_q.pop_front());
            if (pu) exp_q.push_back(pix);
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (bus.valid_out !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.valid_out); else n_pass++;
        n_total++; if (bus.full_out !== 1'b0) $display("FAIL reset_full got %b exp 0", bus.full_out); else n_pass++;
        n_total++; if (bus.row_space_out !== 1'b1) $display("FAIL reset_row_space got %b exp 1", bus.row_space_out); else n_pass++;
        n_total++; if (bus.count_out !== 5'd0) $display("FAIL reset_count got %0d exp 0", bus.count_out); else n_pass++;
        n_total++; if (bus.pixel_out !== 6'h00) $display("FAIL reset_pixel got %h exp 00", bus.pixel_out); else n_pass++;
        n_total++; if ({bus.overflow_out, bus.underflow_out} !== 2'b00)
            $display("FAIL reset_sticky got %b exp 00", {bus.overflow_out, bus.underflow_out}); else n_pass++;
    endtask

    task automatic test_fill_row();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, WIDTH'(i), 1'b0, 1'b0);
            if (i == 1) begin
                n_total++; if (bus.pixel_out !== 6'h01) $display("FAIL push_latency got %h exp 01", bus.pixel_out); else n_pass++;
            end
        end
        n_total++; if (bus.count_out !== 5'd8) $display("FAIL row_count got %0d exp 8", bus.count_out); else n_pass++;
        n_total++; if (bus.row_space_out !== 1'b1) $display("FAIL row_space8 got %b exp 1", bus.row_space_out); else n_pass++;
        n_total++; if (bus.pixel_out !== 6'h01) $display("FAIL row_head got %h exp 01", bus.pixel_out); else n_pass++;
    endtask

    task automatic test_fill_full();
        for (int i = 9; i <= 16; i++) begin
            drive(1'b1, WIDTH'(i), 1'b0, 1'b0);
            if (i == 9) begin
                n_total++; if (bus.row_space_out !== 1'b0) $display("FAIL row_space9 got %b exp 0", bus.row_space_out); else n_pass++;
            end
            if (i == 15) begin
                n_total++; if (bus.full_out !== 1'b0) $display("FAIL full_at15 got %b exp 0", bus.full_out); else n_pass++;
            end
        end
        n_total++; if (bus.full_out !== 1'b1) $display("FAIL full_flag got %b exp 1", bus.full_out); else n_pass++;
        drive(1'b1, 6'h3F, 1'b0, 1'b0);
        n_total++; if (bus.count_out !== 5'd16) $display("FAIL overflow_count got %0d exp 16", bus.count_out); else n_pass++;
        n_total++; if (bus.overflow_out !== 1'b1) $display("FAIL overflow_flag got %b exp 1", bus.overflow_out); else n_pass++;
        n_total++; if (bus.pixel_out !== 6'h01) $display("FAIL overflow_head got %h exp 01", bus.pixel_out); else n_pass++;
    endtask

    task automatic test_push_pop_full();
        n_total++; if (bus.pixel_out !== exp_q[0]) $display("FAIL pp_full_head got %h exp %h", bus.pixel_out, exp_q[0]); else n_pass++;
        drive(1'b1, 6'h2A, 1'b1, 1'b0);
        n_total++; if (bus.count_out !== 5'd16) $display("FAIL pp_full_count got %0d exp 16", bus.count_out); else n_pass++;
        n_total++; if (bus.pixel_out !== 6'h02) $display("FAIL pp_full_newhead got %h exp 02", bus.pixel_out); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (bus.pixel_out !== exp_q[0]) $display("FAIL drain[%0d] got %h exp %h", i, bus.pixel_out, exp_q[0]);
            else n_pass++;
            if (i == 15) begin
                n_total++; if (bus.pixel_out !== 6'h2A) $display("FAIL drain_last got %h exp 2a", bus.pixel_out); else n_pass++;
            end
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        n_total++; if ({bus.valid_out, bus.count_out} !== 6'd0)
            $display("FAIL drain_empty got valid %b count %0d exp 0/0", bus.valid_out, bus.count_out); else n_pass++;
    endtask

    task automatic test_wrap();
        int  max_cnt = 0;
        int  order_err = 0;
        for (int i = 0; i < 43; i++) begin
            bit push = (i < 40);
            bit pop  = (i >= 3);
            if (pop) begin
                n_total++;
                if (bus.pixel_out !== exp_q[0]) begin
                    $display("FAIL wrap_order[%0d] got %h exp %h", i, bus.pixel_out, exp_q[0]);
                    order_err++;
                end else n_pass++;
            end
            drive(push, WIDTH'($urandom_range(0, 63)), pop, 1'b0);
            if (int'(bus.count_out) > max_cnt) max_cnt = int'(bus.count_out);
        end
        n_total++; if (max_cnt > 4) $display("FAIL wrap_max_count got %0d exp <=4", max_cnt); else n_pass++;
        n_total++; if (bus.count_out !== 5'd0) $display("FAIL wrap_end_count got %0d exp 0", bus.count_out); else n_pass++;
        n_total++; if (bus.underflow_out !== 1'b0) $display("FAIL wrap_no_underflow got %b exp 0", bus.underflow_out); else n_pass++;
    endtask

    task automatic test_underflow();
        drive(1'b0, '0, 1'b1, 1'b0);
        n_total++; if (bus.underflow_out !== 1'b1) $display("FAIL underflow_flag got %b exp 1", bus.underflow_out); else n_pass++;
        n_total++; if (bus.count_out !== 5'd0) $display("FAIL underflow_count got %0d exp 0", bus.count_out); else n_pass++;
        drive(1'b1, 6'h05, 1'b1, 1'b0);
        n_total++; if (bus.count_out !== 5'd1) $display("FAIL empty_pp_count got %0d exp 1", bus.count_out); else n_pass++;
        n_total++; if (bus.pixel_out !== 6'h05) $display("FAIL empty_pp_pixel got %h exp 05", bus.pixel_out); else n_pass++;
        drive(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) drive(1'b1, WIDTH'(6'h30 + i), 1'b0, 1'b0);
        drive(1'b1, 6'h3E, 1'b0, 1'b1);
        n_total++; if (bus.count_out !== 5'd0) $display("FAIL flush_count got %0d exp 0", bus.count_out); else n_pass++;
        n_total++; if (bus.valid_out !== 1'b0) $display("FAIL flush_valid got %b exp 0", bus.valid_out); else n_pass++;
        n_total++; if ({bus.overflow_out, bus.underflow_out} !== {m_ovf, m_udf})
            $display("FAIL flush_sticky got %b exp %b", {bus.overflow_out, bus.underflow_out}, {m_ovf, m_udf}); else n_pass++;
        drive(1'b1, 6'h11, 1'b0, 1'b0);
        n_total++; if (bus.pixel_out !== 6'h11) $display("FAIL flush_then_push got %h exp 11", bus.pixel_out); else n_pass++;
        n_total++; if (bus.count_out !== 5'd1) $display("FAIL flush_then_count got %0d exp 1", bus.count_out); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) drive(1'b1, WIDTH'(6'h20 + i), 1'b0, 1'b0);
        do_reset();
        n_total++; if (bus.count_out !== 5'd0) $display("FAIL midrst_count got %0d exp 0", bus.count_out); else n_pass++;
        n_total++; if ({bus.overflow_out, bus.underflow_out} !== 2'b00)
            $display("FAIL midrst_sticky got %b exp 00", {bus.overflow_out, bus.underflow_out}); else n_pass++;
        drive(1'b1, 6'h22, 1'b0, 1'b0);
        drive(1'b1, 6'h23, 1'b0, 1'b0);
        n_total++; if (bus.pixel_out !== 6'h22) $display("FAIL midrst_head got %h exp 22", bus.pixel_out); else n_pass++;
        drive(1'b0, '0, 1'b1, 1'b0);
        n_total++; if (bus.pixel_out !== exp_q[0]) $display("FAIL midrst_next got %h exp %h", bus.pixel_out, exp_q[0]); else n_pass++;
    endtask

    initial begin
        bus.flush_in = 1'b0;
        bus.push_in  = 1'b0;
        bus.pop_in   = 1'b0;
        bus.pixel_in = '0;
        test_reset();
        test_fill_row();
        test_fill_full();
        test_push_pop_full();
        test_wrap();
        test_underflow();
        test_flush();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
